// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_pkg
// Purpose  : Shared FSM state type and width helpers for hamming_stream.
// Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Result width must hold the value n itself, not n-1.
  function automatic int result_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int pop_width(input int m);
    return $clog2(m + 1);
  endfunction

  function automatic int cnt_width(input int cc);
    return (cc > 1) ? $clog2(cc) : 1;
  endfunction

  function automatic bit slices_divide(input int n, input int cc);
    return (cc > 0) && ((n % cc) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_stream_popcount_m.sv
`default_nettype none
// ============================================================================
// Module   : popcount_m
// Purpose  : Combinational adder-tree population count of an M-bit vector.
// Revision : 1.0 - initial release
// ============================================================================
module popcount_m
  import hamming_pkg::*;
#(
  parameter  int M  = 16,
  localparam int PW = pop_width(M)
) (
  input  logic [M-1:0]  vec,
  output logic [PW-1:0] count
);

  generate
    if (M == 1) begin : g_leaf
      assign count = vec;
    end else begin : g_split
      // Split into two halves and recurse; the tree depth is log2(M).
      localparam int ML = M / 2;
      localparam int MH = M - ML;
      localparam int PL = pop_width(ML);
      localparam int PH = pop_width(MH);

      logic [PL-1:0] w_lo;
      logic [PH-1:0] w_hi;

      popcount_m #(.M(ML)) u_lo (.vec(vec[ML-1:0]), .count(w_lo));
      popcount_m #(.M(MH)) u_hi (.vec(vec[M-1:ML]), .count(w_hi));

      assign count = PW'(w_lo) + PW'(w_hi);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/hamming_stream.sv
`default_nettype none
// ============================================================================
// Module   : hamming_stream
// Purpose  : Sliced Hamming-distance engine, CC beats of M bits per result.
//            Optional threshold compare enabled by HAMMING_THR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_stream
  import hamming_pkg::*;
#(
  parameter  int N  = 64,
  parameter  int CC = 4,
  localparam int M  = N / CC,
  localparam int W  = result_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [M-1:0] g_input,
  input  logic [M-1:0] e_input,
  output logic         in_ready,
  output logic         busy,
  output logic [W-1:0] o,
  output logic         o_valid
`ifdef HAMMING_THR_EN
  ,
  input  logic [W-1:0] thr,
  output logic         below
`endif
);

  localparam int PW = pop_width(M);
  localparam int CW = cnt_width(CC);

  generate
    if (!slices_divide(N, CC)) begin : g_bad_split
      $error("hamming_stream: CC must divide N evenly");
    end
  endgenerate

  state_t          r_state;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_o;
  logic [PW-1:0]   w_pop;
  logic [W-1:0]    w_sum;
  logic            w_beat;
  logic            w_last;

  popcount_m #(.M(M)) u_popcount (
    .vec   (g_input ^ e_input),
    .count (w_pop)
  );

  assign w_sum  = r_acc + W'(w_pop);
  assign w_beat = (r_state == ACCUM) && in_valid;
  assign w_last = (r_cnt == CW'(CC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_o     <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCUM: begin
          if (w_beat) begin
            if (w_last) begin
              r_state <= DONE;
              r_o     <= w_sum;
              r_cnt   <= '0;
            end else begin
              r_acc   <= w_sum;
              r_cnt   <= r_cnt + CW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef HAMMING_THR_EN
  logic r_below;

  // Compared against thr as sampled on the final beat, then held with o.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_below <= 1'b0;
    end else if (w_beat && w_last) begin
      r_below <= (w_sum <= thr);
    end
  end

  assign below = r_below;
`endif

  assign in_ready = (r_state == ACCUM);
  assign busy     = (r_state == ACCUM);
  assign o_valid  = (r_state == DONE);
  assign o        = r_o;

endmodule
`default_nettype wire

// File: tb/tb_hamming_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_stream
// Purpose  : Directed plus randomized self-checking bench for hamming_stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_stream;

  logic clk;
  logic rst;

  // Small instance: N=8, CC=2, M=4, W=4
  logic       start8, v8;
  logic [3:0] g8, e8;
  logic       rdy8, busy8, ov8;
  logic [3:0] o8;
  // Wide instance: N=64, CC=4, M=16, W=7
  logic        start64, v64;
  logic [15:0] g64, e64;
  logic        rdy64, busy64, ov64;
  logic [6:0]  o64;
`ifdef HAMMING_THR_EN
  logic [3:0] thr8;
  logic       below8;
  logic [6:0] thr64;
  logic       below64;
`endif

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hamming_stream #(.N(8), .CC(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_valid(v8),
    .g_input(g8), .e_input(e8), .in_ready(rdy8), .busy(busy8),
    .o(o8), .o_valid(ov8)
`ifdef HAMMING_THR_EN
    , .thr(thr8), .below(below8)
`endif
  );

  hamming_stream #(.N(64), .CC(4)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .in_valid(v64),
    .g_input(g64), .e_input(e64), .in_ready(rdy64), .busy(busy64),
    .o(o64), .o_valid(ov64)
`ifdef HAMMING_THR_EN
    , .thr(thr64), .below(below64)
`endif
  );

  // Reference: distance is the number of differing bit positions.
  function automatic int ref_dist(input logic [63:0] a, input logic [63:0] b);
    int d = 0;
    for (int i = 0; i < 64; i++) if (a[i] != b[i]) d++;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_o8 = 4'd0;
  logic       exp_below8 = 1'b0;

  // Entered with start about to be sampled (IDLE or DONE); leaves in DONE.
  task automatic comp8(input logic [7:0] a, input logic [7:0] b, input int stall,
                       input bit poke_start, input int thr_val);
    int d;
    d = ref_dist({56'd0, a}, {56'd0, b});
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("accum_ready", {63'd0, rdy8}, 64'd1);
    chk("accum_busy",  {63'd0, busy8}, 64'd1);
    chk("o_held_new_start", {60'd0, o8}, {60'd0, exp_o8});
    v8 = 1'b1; g8 = a[3:0]; e8 = b[3:0];
    tick();
    v8 = 1'b0;
    g8 = 4'($urandom); e8 = 4'($urandom);
    for (int s = 0; s < stall; s++) begin
      start8 = poke_start;
      tick();
      chk("stall_ready", {63'd0, rdy8}, 64'd1);
      chk("stall_no_valid", {63'd0, ov8}, 64'd0);
    end
    start8 = 1'b0;
    chk("pre_last_no_valid", {63'd0, ov8}, 64'd0);
`ifdef HAMMING_THR_EN
    thr8 = 4'(thr_val);
`endif
    v8 = 1'b1; g8 = a[7:4]; e8 = b[7:4];
    tick();
    v8 = $urandom_range(0, 1) != 0;
    g8 = 4'($urandom); e8 = 4'($urandom);
    exp_o8 = 4'(d);
    exp_below8 = (d <= thr_val);
    chk("done_valid", {63'd0, ov8}, 64'd1);
    chk("done_o", {60'd0, o8}, {60'd0, exp_o8});
    chk("done_busy", {63'd0, busy8}, 64'd0);
    chk("done_ready", {63'd0, rdy8}, 64'd0);
`ifdef HAMMING_THR_EN
    chk("done_below", {63'd0, below8}, {63'd0, exp_below8});
    thr8 = 4'($urandom);
`endif
  endtask

  initial begin
    rst = 1'b0;
    start8 = 0; v8 = 0; g8 = 0; e8 = 0;
    start64 = 0; v64 = 0; g64 = 0; e64 = 0;
`ifdef HAMMING_THR_EN
    thr8 = 0; thr64 = 0;
`endif
    tick(); tick();
    chk("rst_o", {60'd0, o8}, 64'd0);
    chk("rst_valid", {63'd0, ov8}, 64'd0);
    chk("rst_ready", {63'd0, rdy8}, 64'd0);
    chk("rst_busy", {63'd0, busy8}, 64'd0);
    rst = 1'b1;
    tick();

    // Idle ignores in_valid
    v8 = 1'b1; g8 = 4'hF; e8 = 4'h0;
    tick();
    chk("idle_ready", {63'd0, rdy8}, 64'd0);
    v8 = 1'b0;

    // Basic A9/7B with o_valid exactly 3 cycles after start
    comp8(8'hA9, 8'h7B, 0, 1'b0, 4);
    // Back-to-back: 74/9D, then FF/FF, then maximum 00/FF
    comp8(8'h74, 8'h9D, 0, 1'b0, 3);
    comp8(8'hFF, 8'hFF, 0, 1'b0, 0);
    comp8(8'h00, 8'hFF, 0, 1'b0, 8);
    v8 = 1'b0;
    tick();
    chk("idle_after_done", {63'd0, ov8}, 64'd0);
    chk("o_holds_idle", {60'd0, o8}, {60'd0, exp_o8});

    // Stall of 3 cycles with start poked during ACCUM
    comp8(8'hA9, 8'h7B, 3, 1'b1, 3);
    v8 = 1'b0;
    tick();
    chk("o_holds_stall", {60'd0, o8}, 64'd4);
`ifdef HAMMING_THR_EN
    tick();
    chk("below_holds", {63'd0, below8}, {63'd0, exp_below8});
`endif

    // Randomized operand pairs with random stalls, back-to-back
    for (int k = 0; k < 20; k++) begin
      comp8(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b1,
            int'($urandom_range(0, 8)));
    end
    v8 = 1'b0;
    tick();

    // Reset after first beat aborts at once
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    v8 = 1'b1; g8 = 4'h9; e8 = 4'hB;
    tick();
    v8 = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_o", {60'd0, o8}, 64'd0);
    chk("abort_ready", {63'd0, rdy8}, 64'd0);
    chk("abort_busy", {63'd0, busy8}, 64'd0);
    chk("abort_valid", {63'd0, ov8}, 64'd0);
`ifdef HAMMING_THR_EN
    chk("abort_below", {63'd0, below8}, 64'd0);
`endif
    exp_o8 = 4'd0;
    tick();
    rst = 1'b1;
    tick();
    comp8(8'hA9, 8'h7B, 0, 1'b0, 4);
    start8 = 1'b0; v8 = 1'b0;
    tick();

    // Wide instance: all-zeros vs all-ones, then one random pair
    for (int r = 0; r < 2; r++) begin
      logic [63:0] ga, eb;
      ga = (r == 0) ? 64'd0 : {$urandom, $urandom};
      eb = (r == 0) ? {64{1'b1}} : {$urandom, $urandom};
      start64 = 1'b1;
      tick();
      start64 = 1'b0;
      for (int s = 0; s < 4; s++) begin
        chk("w64_no_valid", {63'd0, ov64}, 64'd0);
        v64 = 1'b1; g64 = ga[16*s +: 16]; e64 = eb[16*s +: 16];
        tick();
      end
      v64 = 1'b0;
      chk("w64_valid", {63'd0, ov64}, 64'd1);
      chk("w64_o", {57'd0, o64}, 64'(ref_dist(ga, eb)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
